// File: rtl/filter_round_sat_pipe.sv
// ---------------------------------------------------------------------------
// filter_round_sat_pipe
//   Two-stage round / shift / saturate stage between the filter MAC
//   accumulator and the OUT_W-bit output path. Each sample carries a channel
//   tag. Stage 1 applies the right shift with the selected rounding mode at
//   ACC_W+1 bits. Stage 2 limits (saturate or wrap) to OUT_W bits and flags
//   overflow. The channel tag travels with the data.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   acc_in / acc_ch / acc_valid signed accumulator sample, channel tag, strobe
//   rf_sat                      1 = saturate on overflow, 0 = wrap
//   rf_round_mode               00/11 truncate, 01 half up, 10 convergent
//   rf_shift                    right shift added to BASE_SHIFT
//   trig_filter_ovf_flag_clear  per-channel sticky flag clear pulses
//   trig_ovf_cnt_clear          overflow counter clear pulse
//   filter_out / filter_out_ch  result and its channel tag (held when idle)
//   filter_out_valid            one-cycle pulse per output sample
//   ro_filter_ovf_flag          sticky per-channel overflow flags
//   ro_ovf_cnt                  saturating overflow event counter
// ---------------------------------------------------------------------------
module filter_round_sat_pipe #(
  parameter int ACC_W      = 40,
  parameter int OUT_W      = 16,
  parameter int SHIFT_W    = 3,
  parameter int BASE_SHIFT = 0,
  parameter int NUM_CH     = 4,
  parameter int OVF_CNT_W  = 8,
  localparam int CH_W      = $clog2(NUM_CH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ACC_W-1:0]     acc_in,
  input  logic [CH_W-1:0]      acc_ch,
  input  logic                 acc_valid,
  input  logic                 rf_sat,
  input  logic [1:0]           rf_round_mode,
  input  logic [SHIFT_W-1:0]   rf_shift,
  input  logic [NUM_CH-1:0]    trig_filter_ovf_flag_clear,
  input  logic                 trig_ovf_cnt_clear,
  output logic [OUT_W-1:0]     filter_out,
  output logic [CH_W-1:0]      filter_out_ch,
  output logic                 filter_out_valid,
  output logic [NUM_CH-1:0]    ro_filter_ovf_flag,
  output logic [OVF_CNT_W-1:0] ro_ovf_cnt
);

  localparam logic [1:0] RM_HALF_UP = 2'b01;
  localparam logic [1:0] RM_CONV    = 2'b10;

  // Output range expressed at the stage-1 width.
  localparam logic signed [ACC_W:0] OUT_MAX =
    {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] OUT_MIN =
    {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic [ACC_W:0] ONE = {{ACC_W{1'b0}}, 1'b1};

  // ---------------- stage 1: shift and round ----------------
  int unsigned             shift_amt;
  logic signed [ACC_W:0]   acc_ext;
  logic signed [ACC_W:0]   floor_v;
  logic        [ACC_W:0]   half_v;
  logic        [ACC_W:0]   disc_v;
  logic                    round_inc;
  logic signed [ACC_W:0]   round_v;

  // NOTE: every always_comb output gets a default on entry so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    shift_amt = BASE_SHIFT + 32'(rf_shift);
    acc_ext   = {acc_in[ACC_W-1], acc_in};
    floor_v   = acc_ext >>> shift_amt;
    half_v    = '0;
    disc_v    = '0;
    round_inc = 1'b0;
    if (shift_amt != 0) begin
      half_v = ONE << (shift_amt - 1);
      disc_v = acc_ext & ((ONE << shift_amt) - ONE);
      unique case (rf_round_mode)
        RM_HALF_UP: round_inc = (disc_v >= half_v);
        // Exact ties round towards the even neighbour.
        RM_CONV:    round_inc = (disc_v > half_v) || ((disc_v == half_v) && floor_v[0]);
        default:    round_inc = 1'b0;
      endcase
    end
    // Extra MSB guarantees floor + 1 never wraps.
    round_v = floor_v + $signed({{ACC_W{1'b0}}, round_inc});
  end

  logic signed [ACC_W:0] s1_r;
  logic [CH_W-1:0]       s1_ch;
  logic                  s1_sat;
  logic                  s1_valid;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_r     <= '0;
      s1_ch    <= '0;
      s1_sat   <= 1'b0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= acc_valid;
      if (acc_valid) begin
        s1_r   <= round_v;
        s1_ch  <= acc_ch;
        s1_sat <= rf_sat;
      end
    end
  end

  // ---------------- stage 2: limit and flag ----------------
  logic             ovf_hi;
  logic             ovf_lo;
  logic             ovf_evt;
  logic [OUT_W-1:0] limit_v;
  logic [NUM_CH-1:0] flag_set;

  always_comb begin
    ovf_hi   = (s1_r > OUT_MAX);
    ovf_lo   = (s1_r < OUT_MIN);
    ovf_evt  = s1_valid && (ovf_hi || ovf_lo);
    limit_v  = s1_r[OUT_W-1:0];
    if (s1_sat && ovf_hi) limit_v = OUT_MAX[OUT_W-1:0];
    if (s1_sat && ovf_lo) limit_v = OUT_MIN[OUT_W-1:0];
    flag_set = '0;
    if (ovf_evt) flag_set[s1_ch] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filter_out         <= '0;
      filter_out_ch      <= '0;
      filter_out_valid   <= 1'b0;
      ro_filter_ovf_flag <= '0;
      ro_ovf_cnt         <= '0;
    end else begin
      filter_out_valid <= s1_valid;
      if (s1_valid) begin
        filter_out    <= limit_v;
        filter_out_ch <= s1_ch;
      end
      // Set takes priority over a coincident clear.
      ro_filter_ovf_flag <= (ro_filter_ovf_flag & ~trig_filter_ovf_flag_clear) | flag_set;
      if (trig_ovf_cnt_clear)
        ro_ovf_cnt <= ovf_evt ? {{(OVF_CNT_W-1){1'b0}}, 1'b1} : '0;
      else if (ovf_evt && !(&ro_ovf_cnt))
        ro_ovf_cnt <= ro_ovf_cnt + 1'b1;
    end
  end

endmodule
